// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Used by the fetch unit and by its decoder-side consumers.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_ACCESS     = 2'd1,
    FAULT_MISALIGNED = 2'd2
  } fetch_fault_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word read at a time, latched into an
// instruction register handed to decode over valid/ready; redirects flush in-flight work.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_err,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         ir_valid,
  input  logic         ir_ready,
  output logic [31:0]  ir,
  output logic [31:0]  ir_pc,
  output fetch_fault_t ir_fault
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         drop, drop_nxt;
  logic         ir_valid_nxt;
  logic [31:0]  ir_nxt, ir_pc_nxt;
  fetch_fault_t ir_fault_nxt;
  logic         aligned;

  assign aligned  = (pc[1:0] == 2'b00);
  // Request decoded from state and pc only; forced low while reset is held.
  assign mem_req  = rst_n && (state == FETCH_REQ) && aligned;
  assign mem_addr = pc;

  // Next-state and instruction-register update logic.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drop_nxt     = drop;
    ir_valid_nxt = ir_valid;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_fault_nxt = ir_fault;
    if (redirect_valid) begin
      pc_nxt       = redirect_pc;
      ir_valid_nxt = 1'b0;
      case (state)
        FETCH_REQ: begin
          if (mem_req && mem_gnt) begin
            state_nxt = FETCH_WAIT;
            drop_nxt  = 1'b1;
          end else begin
            state_nxt = FETCH_REQ;
          end
        end
        FETCH_WAIT: begin
          // A response in the redirect cycle is simply discarded, nothing left in flight.
          if (mem_rvalid) begin
            state_nxt = FETCH_REQ;
            drop_nxt  = 1'b0;
          end else begin
            drop_nxt  = 1'b1;
          end
        end
        FETCH_HOLD: state_nxt = FETCH_REQ;
        default:    state_nxt = FETCH_REQ;
      endcase
    end else begin
      case (state)
        FETCH_REQ: begin
          if (!aligned) begin
            ir_nxt       = NOP_INSTR;
            ir_pc_nxt    = pc;
            ir_fault_nxt = FAULT_MISALIGNED;
            ir_valid_nxt = 1'b1;
            state_nxt    = FETCH_HOLD;
          end else if (mem_gnt) begin
            state_nxt = FETCH_WAIT;
          end else begin
            state_nxt = FETCH_REQ;
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid) begin
            if (drop) begin
              drop_nxt  = 1'b0;
              state_nxt = FETCH_REQ;
            end else begin
              ir_nxt       = mem_rdata;
              ir_pc_nxt    = pc;
              ir_fault_nxt = mem_err ? FAULT_ACCESS : FAULT_NONE;
              ir_valid_nxt = 1'b1;
              pc_nxt       = pc + 32'd4;
              state_nxt    = FETCH_HOLD;
            end
          end else begin
            state_nxt = FETCH_WAIT;
          end
        end
        FETCH_HOLD: begin
          if (ir_ready) begin
            ir_valid_nxt = 1'b0;
            state_nxt    = FETCH_REQ;
          end else begin
            state_nxt = FETCH_HOLD;
          end
        end
        default: begin
          state_nxt    = FETCH_REQ;
          ir_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, pc and registered decoder-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH_REQ;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      ir_valid <= 1'b0;
      ir       <= NOP_INSTR;
      ir_pc    <= RESET_PC;
      ir_fault <= FAULT_NONE;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      drop     <= drop_nxt;
      ir_valid <= ir_valid_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_fault <= ir_fault_nxt;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32I core. It holds the PC and issues one word-aligned read at a time to instruction memory over a request/grant/response handshake. Each returned word is latched into an instruction register, which is presented with its PC and a fault code to the downstream instruction decoder through a valid/ready handshake. Execute-stage redirects (jumps, taken branches, traps) flush any in-flight fetch and restart at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request; held until mem_gnt.
- mem_addr  out  32  fetch address; equals the current PC while mem_req=1.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  response valid; at most one per granted request, no earlier than the cycle after gnt.
- mem_rdata  in  32  instruction word, valid with mem_rvalid.
- mem_err  in  1  access fault for the response, valid with mem_rvalid.
- redirect_valid  in  1  one-cycle pulse; load redirect_pc and flush.
- redirect_pc  in  32  new PC.
- ir_valid  out  1  ir, ir_pc and ir_fault are valid.
- ir_ready  in  1  decode accepts the instruction this cycle.
- ir  out  32  instruction word for the decoder.
- ir_pc  out  32  address of ir.
- ir_fault  out  2  fault code of type fetch_fault_t.

## Operation
- States:
  - REQ: issue the fetch.
  - WAIT: wait for the response.
  - HOLD: present the instruction to decode.
- Reset state is REQ with pc=RESET_PC and drop=0.
- Output reset values: mem_req=0 while rst_n=0, ir_valid=0, ir=NOP_INSTR (32'h0000_0013), ir_pc=RESET_PC, ir_fault=FAULT_NONE.
- REQ:
  - If pc[1:0]!=0: mem_req=0; latch ir=NOP_INSTR, ir_pc=pc, ir_fault=FAULT_MISALIGNED; go to HOLD. pc is not incremented.
  - Otherwise mem_req=1 and mem_addr=pc. On mem_gnt go to WAIT; otherwise stay.
- WAIT, on mem_rvalid:
  - If drop=1: discard the response, clear drop, go to REQ.
  - Otherwise latch ir=mem_rdata, ir_pc=pc, and ir_fault=FAULT_ACCESS if mem_err else FAULT_NONE; set pc=pc+4 (mod 2^32); go to HOLD.
- HOLD: ir_valid=1 and ir, ir_pc, ir_fault are stable. On ir_ready go to REQ.
- Redirect (highest priority, any state): pc<=redirect_pc, and ir_valid is 0 from the next cycle.
  - In REQ without gnt: stay in REQ. mem_addr changes the next cycle, which is allowed because the request was not granted.
  - In REQ with gnt in the same cycle: go to WAIT with drop=1.
  - In WAIT without rvalid: set drop=1 and stay in WAIT.
  - In WAIT with rvalid in the same cycle: discard the response (drop stays 0) and go to REQ.
  - In HOLD: go to REQ, even if ir_ready=1 in the same cycle. The held instruction is considered flushed, not consumed.
- An access fault does not stop fetching. Decode and trap logic consume the fault and issue a redirect.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no fault.

## Timing
- Minimum latency from the cycle REQ is entered to ir_valid: 2 cycles, given gnt in the first cycle and rvalid in the next.
- Minimum steady-state throughput: one instruction per 3 cycles (REQ, WAIT, HOLD).
- A misaligned PC reaches HOLD 1 cycle after entering REQ, with no memory access.
- ir_valid, ir, ir_pc and ir_fault are registered outputs. mem_req and mem_addr are decoded from state and pc only, with no combinational input-to-output paths.
- ir_valid never drops without ir_ready, except on redirect or reset.
- Reset asserted mid-fetch: everything returns to reset values immediately. A response arriving after reset release with no outstanding request is ignored; drop logic only applies in WAIT.

## Structure
- Shared package holds:
  - fetch_state_t enum: FETCH_REQ, FETCH_WAIT, FETCH_HOLD.
  - fetch_fault_t, 2 bits: FAULT_NONE=0, FAULT_ACCESS=1, FAULT_MISALIGNED=2.
  - NOP_INSTR constant.
- Single module with no sub-module. ir, ir_pc and ir_fault connect directly to the decoder's ir input and its pipeline register.

## Test plan
- Reset release, memory with 0-cycle gnt and 1-cycle rvalid returning 32'h0000_0013, 32'h00A0_0093, ir_ready=1 → ir_pc sequence 0x0, 0x4, 0x8 with those words, ir_valid every 3rd cycle.
- ir_ready held low for 5 cycles in HOLD → ir, ir_pc and ir_valid stable, no mem_req.
- redirect_valid to 0x100 in WAIT, with rvalid arriving 2 cycles later carrying 0xDEADBEEF → word discarded, next mem_addr=0x100, ir_pc=0x100.
- redirect_pc=0x102 → no mem_req, ir=0x0000_0013, ir_pc=0x102, ir_fault=2.
- mem_err=1 on fetch at 0x40 → ir_fault=1, ir_pc=0x40, next fetch at 0x44.
- rst_n pulsed low while in WAIT at pc 0x20 → ir_valid=0 and mem_req=0 immediately, refetch from RESET_PC.
